// File: rtl/uart_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_sched_pkg                                           |
// | Brief  : Shared states, timing constants and ID width helper.     |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
package uart_sched_pkg;

    localparam int BIT_CYC         = 576;
    localparam int FRAME_BITS      = 20;
    localparam int PERIOD_CYC_DEF  = 32 * BIT_CYC;
    localparam int TIMEOUT_CYC_DEF = 16384;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SLOT = 3'd1,
        S_ARB       = 3'd2,
        S_LAUNCH    = 3'd3,
        S_WAIT_DONE = 3'd4
    } sched_state_e;

    // Two requesters still need one ID bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_tx_scheduler_if                                     |
// | Brief  : Scheduler-to-UART-transmitter frame handshake.           |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
interface uart_tx_scheduler_if #(
    parameter int DATA_W = 18,
    parameter int ID_W   = 2
);
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [ID_W-1:0]   tx_id;
    logic              tx_busy;
    logic              tx_done;

    modport master (output tx_start, tx_data, tx_id, input tx_busy, tx_done);
    modport slave  (input tx_start, tx_data, tx_id, output tx_busy, tx_done);
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : rr_arbiter                                               |
// | Brief  : Combinational priority pick rotated to start at rr_ptr.  |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]    i_rr_ptr,
    output logic      [NUM_REQ-1:0] o_winner,
    output logic      [ID_W-1:0]    o_idx,
    output logic                    o_any
);

    int w_k;

    // Scan farthest-to-nearest so the requester closest to rr_ptr overwrites the rest.
    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_k      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_k = (int'(i_rr_ptr) + i) % NUM_REQ;
            if (i_req[w_k]) begin
                o_winner      = '0;
                o_winner[w_k] = 1'b1;
                o_idx         = ID_W'(w_k);
                o_any         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : uart_tx_scheduler                                        |
// | Brief  : Slot-timed round-robin sharing of one UART transmitter.  |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 18,
    parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  wire logic                      sys_clk,
    input  wire logic                      sys_reset,
    input  wire logic                      enable,
    input  wire logic                      err_clr,
    input  wire logic [NUM_REQ-1:0]        req,
    input  wire logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic      [NUM_REQ-1:0]        grant,
    uart_tx_scheduler_if.master            tx_if,
    output logic                           timeout_err,
    output logic      [7:0]                overrun_cnt
);

    localparam int ID_W = id_w(NUM_REQ);
    localparam int PCW  = $clog2(PERIOD_CYC);
    localparam int TCW  = $clog2(TIMEOUT_CYC);

    sched_state_e       r_state;
    logic [PCW-1:0]     r_period_cnt;
    logic [TCW-1:0]     r_timeout_cnt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_tx_start;
    logic [DATA_W-1:0]  r_tx_data;
    logic [ID_W-1:0]    r_tx_id;
    logic               r_timeout_err;
    logic [7:0]         r_overrun_cnt;

    logic [NUM_REQ-1:0] w_winner;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [ID_W-1:0]    w_next_ptr;
    logic               w_slot_tick;
    logic               w_timeout_hit;
    logic               w_overrun_evt;
    logic               w_timeout_evt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_next_ptr    = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    assign w_slot_tick   = (r_period_cnt == PCW'(PERIOD_CYC - 1));
    assign w_timeout_hit = (r_timeout_cnt == TCW'(TIMEOUT_CYC - 1));

    // A slot is lost when it ticks with work pending but the transmitter cannot take it.
    assign w_overrun_evt = enable && w_slot_tick && (|req) &&
                           ((r_state == S_WAIT_DONE) ||
                            ((r_state == S_WAIT_SLOT) && tx_if.tx_busy));
    assign w_timeout_evt = enable && (r_state == S_WAIT_DONE) &&
                           !tx_if.tx_done && w_timeout_hit;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state       <= S_IDLE;
            r_period_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= '0;
            r_tx_id       <= '0;
            r_timeout_err <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            r_grant    <= '0;
            r_tx_start <= 1'b0;

            if (!enable || w_slot_tick) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end

            if (err_clr) begin
                r_timeout_err <= 1'b0;
                r_overrun_cnt <= '0;
            end else begin
                if (w_timeout_evt) begin
                    r_timeout_err <= 1'b1;
                end
                if (w_overrun_evt && (r_overrun_cnt != 8'hFF)) begin
                    r_overrun_cnt <= r_overrun_cnt + 1'b1;
                end
            end

            if (!enable) begin
                r_state       <= S_IDLE;
                r_timeout_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_timeout_cnt <= '0;
                        r_state       <= S_WAIT_SLOT;
                    end
                    S_WAIT_SLOT: begin
                        if (w_slot_tick && (|req) && !tx_if.tx_busy) begin
                            r_state <= S_ARB;
                        end
                    end
                    S_ARB: begin
                        if (w_any) begin
                            r_grant   <= w_winner;
                            r_tx_data <= req_data[int'(w_idx)*DATA_W +: DATA_W];
                            r_tx_id   <= w_idx;
                            r_rr_ptr  <= w_next_ptr;
                            r_state   <= S_LAUNCH;
                        end else begin
                            r_state <= S_WAIT_SLOT;
                        end
                    end
                    S_LAUNCH: begin
                        r_tx_start    <= 1'b1;
                        r_timeout_cnt <= '0;
                        r_state       <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                        if (tx_if.tx_done || w_timeout_hit) begin
                            r_state <= S_WAIT_SLOT;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign grant          = r_grant;
    assign tx_if.tx_start = r_tx_start;
    assign tx_if.tx_data  = r_tx_data;
    assign tx_if.tx_id    = r_tx_id;
    assign timeout_err    = r_timeout_err;
    assign overrun_cnt    = r_overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_uart_tx_scheduler                                     |
// | Brief  : Directed self-checking bench, PERIOD=16, TIMEOUT=40.     |
// | Rev    : 1.0                                                      |
// +------------------------------------------------------------------+
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        err_clr;
    logic [3:0]  req;
    logic [71:0] req_data;
    logic [3:0]  grant;
    logic        timeout_err;
    logic [7:0]  overrun_cnt;

    logic [17:0] dv [4];
    int          n;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  grant_seen;
    logic        start_seen;

    uart_tx_scheduler_if #(.DATA_W(18), .ID_W(2)) tx_if ();

    uart_tx_scheduler #(
        .NUM_REQ     (4),
        .DATA_W      (18),
        .PERIOD_CYC  (16),
        .TIMEOUT_CYC (40)
    ) dut (
        .sys_clk     (clk),
        .sys_reset   (rst),
        .enable      (enable),
        .err_clr     (err_clr),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .tx_if       (tx_if),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // n counts cycles since enable rose; the slot tick falls on n%16==15.
    task automatic tick1();
        @(posedge clk);
        #1;
        n++;
        grant_seen = grant_seen | grant;
        start_seen = start_seen | tx_if.tx_start;
    endtask

    task automatic go_to(input int t);
        while (n < t) tick1();
    endtask

    task automatic restart();
        rst           = 1'b1;
        enable        = 1'b0;
        req           = '0;
        err_clr       = 1'b0;
        tx_if.tx_busy = 1'b0;
        tx_if.tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        enable     = 1'b1;
        n          = 0;
        grant_seen = '0;
        start_seen = 1'b0;
    endtask

    initial begin
        dv[0] = 18'h00011;
        dv[1] = 18'h12345;
        dv[2] = 18'h2A5A5;
        dv[3] = 18'h3C3C3;
        req_data = {dv[3], dv[2], dv[1], dv[0]};

        // Reset values
        restart();
        chk("rst_grant", grant, 0);
        chk("rst_start", tx_if.tx_start, 0);
        chk("rst_data", tx_if.tx_data, 0);
        chk("rst_id", tx_if.tx_id, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_ovr", overrun_cnt, 0);

        // Single requester with a normal completion
        req = 4'b0100;
        go_to(16);
        chk("single_arb_nogrant", grant, 0);
        go_to(17);
        chk("single_grant", grant, 4'b0100);
        chk("single_id", tx_if.tx_id, 2);
        chk("single_data", tx_if.tx_data, 18'h2A5A5);
        chk("single_nostart", tx_if.tx_start, 0);
        req = '0;
        go_to(18);
        chk("single_start", tx_if.tx_start, 1);
        chk("single_grant_off", grant, 0);
        tx_if.tx_busy = 1'b1;
        go_to(19);
        chk("single_start_pulse", tx_if.tx_start, 0);
        go_to(38);
        tx_if.tx_done = 1'b1;
        tick1();
        tx_if.tx_done = 1'b0;
        tx_if.tx_busy = 1'b0;
        go_to(60);
        chk("single_no_terr", timeout_err, 0);

        // All four requesting: rotation 0,1,2,3,0
        restart();
        req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            go_to(16 * s + 16);
            chk("rr_pre", grant, 0);
            go_to(16 * s + 17);
            chk("rr_grant", grant, 4'b0001 << (s % 4));
            chk("rr_id", tx_if.tx_id, s % 4);
            chk("rr_data", tx_if.tx_data, dv[s % 4]);
            go_to(16 * s + 18);
            chk("rr_start", tx_if.tx_start, 1);
            chk("rr_post", grant, 0);
            go_to(16 * s + 20);
            tx_if.tx_done = 1'b1;
            tick1();
            tx_if.tx_done = 1'b0;
        end
        chk("rr_no_ovr", overrun_cnt, 0);

        // Busy transmitter: slots lost, clear, clear-vs-increment, saturation
        restart();
        req           = 4'b0001;
        tx_if.tx_busy = 1'b1;
        go_to(48);
        chk("busy_ovr3", overrun_cnt, 3);
        chk("busy_nogrant", grant_seen, 0);
        err_clr = 1'b1;
        tick1();
        err_clr = 1'b0;
        chk("busy_clr", overrun_cnt, 0);
        go_to(63);
        err_clr = 1'b1;
        tick1();
        err_clr = 1'b0;
        chk("busy_clr_wins", overrun_cnt, 0);
        go_to(4224);
        chk("busy_sat", overrun_cnt, 255);
        go_to(4240);
        chk("busy_sat_hold", overrun_cnt, 255);
        chk("busy_nostart", start_seen, 0);
        tx_if.tx_busy = 1'b0;

        // Timeout: no tx_done, error 40 cycles after tx_start
        restart();
        req = 4'b0001;
        go_to(17);
        chk("to_grant", grant, 4'b0001);
        req = '0;
        go_to(18);
        chk("to_start", tx_if.tx_start, 1);
        go_to(57);
        chk("to_early", timeout_err, 0);
        go_to(58);
        chk("to_set", timeout_err, 1);
        chk("to_no_ovr", overrun_cnt, 0);
        req = 4'b0010;
        go_to(65);
        chk("to_next_grant", grant, 4'b0010);
        req = '0;
        go_to(66);
        chk("to_next_start", tx_if.tx_start, 1);
        chk("to_sticky", timeout_err, 1);
        go_to(68);
        tx_if.tx_done = 1'b1;
        tick1();
        tx_if.tx_done = 1'b0;
        go_to(70);
        err_clr = 1'b1;
        tick1();
        err_clr = 1'b0;
        chk("to_clr", timeout_err, 0);

        // tx_done on the 40th cycle beats the timeout; err_clr beats a timeout set
        restart();
        req = 4'b0001;
        go_to(17);
        req = '0;
        go_to(57);
        tx_if.tx_done = 1'b1;
        tick1();
        tx_if.tx_done = 1'b0;
        chk("done_wins", timeout_err, 0);
        go_to(60);
        chk("done_wins_hold", timeout_err, 0);
        req = 4'b0001;
        go_to(65);
        chk("done_next_grant", grant, 4'b0001);
        req = '0;
        go_to(105);
        err_clr = 1'b1;
        tick1();
        err_clr = 1'b0;
        chk("clr_over_timeout", timeout_err, 0);
        go_to(107);
        chk("clr_over_timeout_hold", timeout_err, 0);

        // Request withdrawn before arbitration
        restart();
        req = 4'b0001;
        go_to(16);
        req = '0;
        go_to(20);
        chk("drop_nogrant", grant_seen, 0);
        chk("drop_nostart", start_seen, 0);
        req = 4'b1111;
        go_to(33);
        chk("drop_ptr_kept", grant, 4'b0001);

        // Disable mid-frame, then re-enable
        restart();
        req = 4'b1111;
        go_to(17);
        chk("dis_grant", grant, 4'b0001);
        req = '0;
        go_to(20);
        enable = 1'b0;
        tick1();
        chk("dis_nostart", tx_if.tx_start, 0);
        chk("dis_data_kept", tx_if.tx_data, dv[0]);
        tick1();
        req        = 4'b1111;
        enable     = 1'b1;
        n          = 0;
        grant_seen = '0;
        start_seen = 1'b0;
        go_to(16);
        chk("dis_restart_nogrant", grant_seen, 0);
        chk("dis_restart_nostart", start_seen, 0);
        go_to(17);
        chk("dis_restart_grant", grant, 4'b0010);

        // Reset while in LAUNCH
        restart();
        req = 4'b0010;
        go_to(17);
        chk("rl_grant", grant, 4'b0010);
        rst = 1'b1;
        tick1();
        chk("rl_start", tx_if.tx_start, 0);
        chk("rl_grant0", grant, 0);
        chk("rl_data", tx_if.tx_data, 0);
        chk("rl_id", tx_if.tx_id, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
